// File: rtl/turn_sequencer.sv
// turn_sequencer: Battleship game-flow FSM. It sequences player and PC turns, owns the shot port and tallies hits.
// Define TURN_TIMER_EN to enable the per-turn tick timer. Without it, P_WAIT waits indefinitely and time_left reads 0.
`timescale 1ns/1ps
module turn_sequencer #(
   parameter int unsigned TURN_TICKS  = 15,
   parameter int unsigned HITS_TO_WIN = 5,
   parameter logic [5:0]  PC_SEED     = 6'h2D,
   parameter logic [5:0]  PC_STRIDE   = 6'd37
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       boats_placed,
   input  logic       tick,
   input  logic       player_move,
   input  logic [2:0] cur_i,
   input  logic [2:0] cur_j,
   output logic       shot_req,
   output logic       shot_target,
   output logic [2:0] shot_i,
   output logic [2:0] shot_j,
   input  logic       shot_ack,
   input  logic       shot_hit,
   input  logic       shot_dup,
   output logic       player_turn,
   output logic       pc_turn,
   output logic [4:0] time_left,
   output logic [3:0] player_hits,
   output logic [3:0] pc_hits,
   output logic       is_victory,
   output logic       is_defeat
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_P_WAIT, S_P_SHOT, S_PC_AIM, S_PC_SHOT, S_WIN, S_LOSE
   } state_t;

   localparam logic [3:0] HITS_MAX = 4'(HITS_TO_WIN);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_ptr;
   logic [5:0] w_ptr_next;
   logic [2:0] r_shot_i;
   logic [2:0] r_shot_j;
   logic [3:0] r_player_hits;
   logic [3:0] r_pc_hits;
   logic       w_expire;
   logic       w_player_win;
   logic       w_pc_win;

   assign w_ptr_next   = r_ptr + PC_STRIDE;
   // The hit counters never exceed HITS_MAX-1 while a shot is pending, so +1 cannot wrap.
   assign w_player_win = shot_hit && ((r_player_hits + 4'd1) == HITS_MAX);
   assign w_pc_win     = shot_hit && ((r_pc_hits + 4'd1) == HITS_MAX);

`ifdef TURN_TIMER_EN
   localparam logic [4:0] TICKS_INIT = 5'(TURN_TICKS);
   logic [4:0] r_time_left;

   assign w_expire  = tick && (r_time_left == 5'd1);
   assign time_left = r_time_left;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_time_left <= '0;
      end else if (w_next == S_P_WAIT && (r_state == S_SETUP || r_state == S_PC_SHOT)) begin
         r_time_left <= TICKS_INIT;
      end else if (r_state == S_P_WAIT && !player_move && tick) begin
         r_time_left <= r_time_left - 5'd1;
      end
   end
`else
   logic w_unused_tick;
   assign w_unused_tick = tick;
   assign w_expire      = 1'b0;
   assign time_left     = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: every sequential element uses non-blocking assignment so all registers update from pre-edge values.
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      // NOTE: each output is given a default first, so no path through the case can infer a latch.
      w_next      = r_state;
      shot_req    = 1'b0;
      shot_target = 1'b0;
      player_turn = 1'b0;
      pc_turn     = 1'b0;
      is_victory  = 1'b0;
      is_defeat   = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_SETUP;
         S_SETUP: if (boats_placed) w_next = S_P_WAIT;
         S_P_WAIT: begin
            player_turn = 1'b1;
            if (player_move)   w_next = S_P_SHOT;
            else if (w_expire) w_next = S_PC_AIM;
         end
         S_P_SHOT: begin
            shot_req = 1'b1;
            if (shot_ack) begin
               if (shot_dup)          w_next = S_P_WAIT;
               else if (w_player_win) w_next = S_WIN;
               else                   w_next = S_PC_AIM;
            end
         end
         S_PC_AIM: begin
            pc_turn = 1'b1;
            w_next  = S_PC_SHOT;
         end
         S_PC_SHOT: begin
            pc_turn     = 1'b1;
            shot_req    = 1'b1;
            shot_target = 1'b1;
            if (shot_ack) begin
               if (shot_dup)      w_next = S_PC_AIM;
               else if (w_pc_win) w_next = S_LOSE;
               else               w_next = S_P_WAIT;
            end
         end
         S_WIN: begin
            is_victory = 1'b1;
            if (start) w_next = S_IDLE;
         end
         S_LOSE: begin
            is_defeat = 1'b1;
            if (start) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The PC pointer survives across games and returns to PC_SEED only on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr         <= PC_SEED;
         r_shot_i      <= '0;
         r_shot_j      <= '0;
         r_player_hits <= '0;
         r_pc_hits     <= '0;
      end else begin
         if (r_state == S_P_WAIT && player_move) begin
            r_shot_i <= cur_i;
            r_shot_j <= cur_j;
         end
         if (r_state == S_PC_AIM) begin
            r_ptr    <= w_ptr_next;
            r_shot_i <= w_ptr_next[5:3];
            r_shot_j <= w_ptr_next[2:0];
         end
         if (w_next == S_IDLE && r_state != S_IDLE) begin
            r_player_hits <= '0;
            r_pc_hits     <= '0;
         end
         if (r_state == S_P_SHOT && shot_ack && !shot_dup && shot_hit && r_player_hits < HITS_MAX)
            r_player_hits <= r_player_hits + 4'd1;
         if (r_state == S_PC_SHOT && shot_ack && !shot_dup && shot_hit && r_pc_hits < HITS_MAX)
            r_pc_hits <= r_pc_hits + 4'd1;
      end
   end

   assign shot_i      = r_shot_i;
   assign shot_j      = r_shot_j;
   assign player_hits = r_player_hits;
   assign pc_hits     = r_pc_hits;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: scoreboard bench for turn_sequencer. Expected shots are queued on stimulus and popped on shot_req.
`timescale 1ns/1ps
module tb_turn_sequencer;

   localparam int         TB_TICKS  = 3;
   localparam int         TB_HITS   = 2;
   localparam logic [5:0] TB_SEED   = 6'h2D;
   localparam logic [5:0] TB_STRIDE = 6'd37;

`ifdef TURN_TIMER_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, boats_placed = 1'b0, tick = 1'b0, player_move = 1'b0;
   logic [2:0] cur_i = '0, cur_j = '0;
   logic       shot_ack = 1'b0, shot_hit = 1'b0, shot_dup = 1'b0;
   logic       shot_req, shot_target, player_turn, pc_turn, is_victory, is_defeat;
   logic [2:0] shot_i, shot_j;
   logic [4:0] time_left;
   logic [3:0] player_hits, pc_hits;

   turn_sequencer #(
      .TURN_TICKS(TB_TICKS), .HITS_TO_WIN(TB_HITS), .PC_SEED(TB_SEED), .PC_STRIDE(TB_STRIDE)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .boats_placed(boats_placed), .tick(tick),
      .player_move(player_move), .cur_i(cur_i), .cur_j(cur_j),
      .shot_req(shot_req), .shot_target(shot_target), .shot_i(shot_i), .shot_j(shot_j),
      .shot_ack(shot_ack), .shot_hit(shot_hit), .shot_dup(shot_dup),
      .player_turn(player_turn), .pc_turn(pc_turn), .time_left(time_left),
      .player_hits(player_hits), .pc_hits(pc_hits),
      .is_victory(is_victory), .is_defeat(is_defeat)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [6:0] exp_q[$];
   logic [5:0] m_ptr = TB_SEED;
   int         m_time = 0;
   int         m_player_hits = 0;
   int         m_pc_hits = 0;

   function automatic logic [4:0] exp_tl(input int t);
      return TIMER_ON ? 5'(t) : 5'd0;
   endfunction

   function automatic logic [24:0] all_outs();
      return {shot_req, shot_target, shot_i, shot_j, player_turn, pc_turn, time_left,
              player_hits, pc_hits, is_victory, is_defeat};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game();
      start = 1'b1;
      step();
      start = 1'b0;
      boats_placed = 1'b1;
      step();
      boats_placed = 1'b0;
      m_time = TB_TICKS;
      n_tests++;
      if (player_turn !== 1'b1 || time_left !== exp_tl(m_time)) begin
         n_fail++;
         $display("FAIL start_game: player_turn=%b time_left=%0d want 1/%0d", player_turn, time_left, exp_tl(m_time));
      end
   endtask

   task automatic fire(input logic [2:0] i, input logic [2:0] j);
      cur_i = i;
      cur_j = j;
      player_move = 1'b1;
      exp_q.push_back({1'b0, i, j});
      step();
      player_move = 1'b0;
      n_tests++;
      if (shot_req !== 1'b1) begin
         n_fail++;
         $display("FAIL fire_latency: shot_req=%b want 1", shot_req);
      end
   endtask

   task automatic wait_req(input string name);
      int         n = 0;
      logic [6:0] e_val;
      while (shot_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: request {%b,%0d,%0d} with empty scoreboard", name, shot_target, shot_i, shot_j);
      end else begin
         e_val = exp_q.pop_front();
         if (shot_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: no shot_req within 20 cycles, want {%b,%0d,%0d}", name, e_val[6], e_val[5:3], e_val[2:0]);
         end else if ({shot_target, shot_i, shot_j} !== e_val) begin
            n_fail++;
            $display("FAIL %s: got {%b,%0d,%0d} want {%b,%0d,%0d}", name, shot_target, shot_i, shot_j,
                     e_val[6], e_val[5:3], e_val[2:0]);
         end
      end
   endtask

   task automatic drive_ack(input logic hit, input logic dup);
      shot_ack = 1'b1;
      shot_hit = hit;
      shot_dup = dup;
      step();
      shot_ack = 1'b0;
      shot_hit = 1'b0;
      shot_dup = 1'b0;
      n_tests++;
      if (shot_req !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_drop: shot_req=%b want 0", shot_req);
      end
   endtask

   task automatic player_ack(input logic hit, input logic dup);
      drive_ack(hit, dup);
      if (!dup) begin
         if (hit) m_player_hits++;
         if (m_player_hits < TB_HITS) begin
            m_ptr = m_ptr + TB_STRIDE;
            exp_q.push_back({1'b1, m_ptr});
         end
      end
      n_tests++;
      if (player_hits !== 4'(m_player_hits)) begin
         n_fail++;
         $display("FAIL player_hits: got %0d want %0d", player_hits, m_player_hits);
      end
   endtask

   task automatic pc_ack(input logic hit, input logic dup);
      drive_ack(hit, dup);
      if (dup) begin
         m_ptr = m_ptr + TB_STRIDE;
         exp_q.push_back({1'b1, m_ptr});
      end else begin
         if (hit) m_pc_hits++;
         if (m_pc_hits < TB_HITS) m_time = TB_TICKS;
      end
      n_tests++;
      if (pc_hits !== 4'(m_pc_hits)) begin
         n_fail++;
         $display("FAIL pc_hits: got %0d want %0d", pc_hits, m_pc_hits);
      end
   endtask

   task automatic test_reset();
      step();
      n_tests++;
      if (all_outs() !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", all_outs());
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic_turn();
      start_game();
      fire(3'd2, 3'd5);
      wait_req("player_shot_2_5");
      player_ack(1'b0, 1'b0);
      n_tests++;
      if (pc_turn !== 1'b1) begin
         n_fail++;
         $display("FAIL pc_aim: pc_turn=%b want 1", pc_turn);
      end
      wait_req("pc_shot_first");
      pc_ack(1'b0, 1'b0);
      n_tests++;
      if (player_turn !== 1'b1 || time_left !== exp_tl(TB_TICKS)) begin
         n_fail++;
         $display("FAIL back_to_player: player_turn=%b time_left=%0d want 1/%0d", player_turn, time_left, exp_tl(TB_TICKS));
      end
   endtask

   task automatic test_dup();
      tick = 1'b1;
      step();
      tick = 1'b0;
      m_time--;
      fire(3'd3, 3'd4);
      wait_req("player_dup_shot");
      player_ack(1'b0, 1'b1);
      n_tests++;
      if (player_turn !== 1'b1 || time_left !== exp_tl(m_time)) begin
         n_fail++;
         $display("FAIL player_dup: player_turn=%b time_left=%0d want 1/%0d", player_turn, time_left, exp_tl(m_time));
      end
      fire(3'd3, 3'd5);
      wait_req("player_after_dup");
      player_ack(1'b0, 1'b0);
      wait_req("pc_before_dup");
      pc_ack(1'b0, 1'b1);
      wait_req("pc_retry");
      pc_ack(1'b0, 1'b0);
   endtask

   task automatic test_timer();
`ifdef TURN_TIMER_EN
      for (int k = 0; k < TB_TICKS; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         m_time--;
         n_tests++;
         if (time_left !== 5'(m_time)) begin
            n_fail++;
            $display("FAIL timer_count: got %0d want %0d", time_left, m_time);
         end
      end
      m_ptr = m_ptr + TB_STRIDE;
      exp_q.push_back({1'b1, m_ptr});
      n_tests++;
      if (pc_turn !== 1'b1) begin
         n_fail++;
         $display("FAIL timer_forfeit: pc_turn=%b want 1", pc_turn);
      end
      wait_req("pc_after_forfeit");
      pc_ack(1'b0, 1'b0);
      for (int k = 0; k < TB_TICKS - 1; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         m_time--;
      end
      cur_i = 3'd1;
      cur_j = 3'd1;
      tick = 1'b1;
      player_move = 1'b1;
      exp_q.push_back({1'b0, 3'd1, 3'd1});
      step();
      tick = 1'b0;
      player_move = 1'b0;
      n_tests++;
      if (shot_req !== 1'b1 || time_left !== 5'd1) begin
         n_fail++;
         $display("FAIL move_beats_tick: shot_req=%b time_left=%0d want 1/1", shot_req, time_left);
      end
      wait_req("player_on_last_tick");
      player_ack(1'b0, 1'b0);
      wait_req("pc_after_last_tick");
      pc_ack(1'b0, 1'b0);
`else
      for (int k = 0; k < 100; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         step();
      end
      n_tests++;
      if (player_turn !== 1'b1 || time_left !== 5'd0) begin
         n_fail++;
         $display("FAIL timer_disabled: player_turn=%b time_left=%0d want 1/0", player_turn, time_left);
      end
`endif
   endtask

   task automatic test_victory();
      shot_ack = 1'b1;
      shot_hit = 1'b1;
      step();
      shot_ack = 1'b0;
      shot_hit = 1'b0;
      n_tests++;
      if (player_hits !== 4'd0 || player_turn !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_ack: player_hits=%0d player_turn=%b want 0/1", player_hits, player_turn);
      end
      fire(3'd0, 3'd0);
      wait_req("win_shot_1");
      player_ack(1'b1, 1'b0);
      wait_req("pc_between_hits");
      pc_ack(1'b0, 1'b0);
      fire(3'd0, 3'd1);
      wait_req("win_shot_2");
      player_ack(1'b1, 1'b0);
      n_tests++;
      if (is_victory !== 1'b1 || player_hits !== 4'(TB_HITS)) begin
         n_fail++;
         $display("FAIL victory: is_victory=%b player_hits=%0d want 1/%0d", is_victory, player_hits, TB_HITS);
      end
      player_move = 1'b1;
      step();
      player_move = 1'b0;
      n_tests++;
      if (is_victory !== 1'b1 || shot_req !== 1'b0) begin
         n_fail++;
         $display("FAIL move_in_win: is_victory=%b shot_req=%b want 1/0", is_victory, shot_req);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      m_player_hits = 0;
      m_pc_hits = 0;
      n_tests++;
      if (is_victory !== 1'b0 || player_hits !== 4'd0 || pc_hits !== 4'd0) begin
         n_fail++;
         $display("FAIL leave_win: is_victory=%b hits=%0d/%0d want 0/0/0", is_victory, player_hits, pc_hits);
      end
   endtask

   task automatic test_defeat();
      start_game();
      fire(3'd1, 3'd2);
      wait_req("defeat_player_1");
      player_ack(1'b0, 1'b0);
      wait_req("defeat_pc_1");
      pc_ack(1'b1, 1'b0);
      fire(3'd1, 3'd3);
      wait_req("defeat_player_2");
      player_ack(1'b0, 1'b0);
      wait_req("defeat_pc_2");
      pc_ack(1'b1, 1'b0);
      n_tests++;
      if (is_defeat !== 1'b1 || pc_hits !== 4'(TB_HITS) || player_turn !== 1'b0) begin
         n_fail++;
         $display("FAIL defeat: is_defeat=%b pc_hits=%0d player_turn=%b want 1/%0d/0", is_defeat, pc_hits, player_turn, TB_HITS);
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1;
      step();
      m_player_hits = 0;
      m_pc_hits = 0;
      step();
      start = 1'b0;
      boats_placed = 1'b1;
      step();
      boats_placed = 1'b0;
      m_time = TB_TICKS;
      n_tests++;
      if (player_turn !== 1'b1 || is_defeat !== 1'b0 || pc_hits !== 4'd0) begin
         n_fail++;
         $display("FAIL held_start: player_turn=%b is_defeat=%b pc_hits=%0d want 1/0/0", player_turn, is_defeat, pc_hits);
      end
      fire(3'd4, 3'd4);
      wait_req("pre_reset_player");
      player_ack(1'b0, 1'b0);
      wait_req("pre_reset_pc");
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (all_outs() !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %h want 0", all_outs());
      end
      step();
      rst = 1'b1;
      m_ptr = TB_SEED;
      m_player_hits = 0;
      m_pc_hits = 0;
      step();
      n_tests++;
      if (all_outs() !== '0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %h want 0", all_outs());
      end
      start_game();
      fire(3'd5, 3'd5);
      wait_req("post_reset_player");
      player_ack(1'b0, 1'b0);
      wait_req("post_reset_pc");
      n_tests++;
      if ({shot_i, shot_j} !== 6'h12) begin
         n_fail++;
         $display("FAIL seed_restart: got %h want 12", {shot_i, shot_j});
      end
      pc_ack(1'b0, 1'b0);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_turn();
      test_dup();
      test_timer();
      test_victory();
      test_defeat();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-flow controller for Battleship. Sequences the player and PC turns, owns the shared shot port into the board store, and enforces a per-turn time limit. Generates PC target cells and tracks hit counts to declare victory or defeat. Sits between the top-level input controls (cursor, fire button, `clk_ms`-derived tick) and the board store and VGA status logic.

## Interface
- `TURN_TICKS`, default 15: ticks allowed per player turn (1..31).
- `HITS_TO_WIN`, default 5: ship cells to sink to end the game (1..15).
- `PC_SEED`, default 6'h2D: initial PC target pointer {i,j}.
- `PC_STRIDE`, default 6'd37: pointer increment per PC aim. Must be odd.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins a game, or leaves WIN/LOSE.
- `boats_placed`  in  1  level; setup complete.
- `tick`  in  1  one-`clk` pulse; turn-timer granularity.
- `player_move`  in  1  one-`clk` fire pulse.
- `cur_i`, `cur_j`  in  3 each  player cursor cell.
- `shot_req`  out  1  shot request to board store.
- `shot_target`  out  1  0 = PC board (player fires), 1 = player board.
- `shot_i`, `shot_j`  out  3 each  target cell.
- `shot_ack`  in  1  board store response strobe.
- `shot_hit`, `shot_dup`  in  1 each  qualified by `shot_ack`; dup = cell already shot.
- `player_turn`, `pc_turn`  out  1 each.
- `time_left`  out  5  remaining ticks in the player turn.
- `player_hits`, `pc_hits`  out  4 each.
- `is_victory`, `is_defeat`  out  1 each.

## Operation
- States: IDLE, SETUP, P_WAIT, P_SHOT, PC_AIM, PC_SHOT, WIN, LOSE.
- IDLE: `start`=1 → SETUP. Hit counters cleared on entry.
- SETUP: `boats_placed`=1 → P_WAIT, `time_left`←TURN_TICKS.
- P_WAIT (`player_turn`=1): `player_move` → P_SHOT, latching cur_i/cur_j into shot_i/shot_j. A `tick` decrements `time_left`. A `tick` at `time_left`=1 → `time_left`=0 and PC_AIM (turn forfeited). If `player_move` and an expiring `tick` arrive together, the move wins and the timer is not decremented.
- P_SHOT: `shot_req`=1, `shot_target`=0, held until `shot_ack`. dup → P_WAIT, timer value kept. hit → `player_hits`+1; reaching HITS_TO_WIN → WIN, else PC_AIM. miss → PC_AIM.
- PC_AIM (`pc_turn`=1, one cycle): pointer ← pointer + PC_STRIDE (mod 64). shot_i = ptr[5:3], shot_j = ptr[2:0] → PC_SHOT. An odd stride covers all 64 cells.
- PC_SHOT (`pc_turn`=1): `shot_req`=1, `shot_target`=1. dup → PC_AIM (retry). hit → `pc_hits`+1; reaching HITS_TO_WIN → LOSE, else P_WAIT. miss → P_WAIT. Entering P_WAIT reloads `time_left`.
- WIN: `is_victory`=1. LOSE: `is_defeat`=1. Both hold until `start`=1 → IDLE. If `start` is held, the next cycle goes to SETUP.
- `shot_ack` outside P_SHOT/PC_SHOT is ignored. `player_move` outside P_WAIT is ignored.

## Timing
- Reset (async, `rst`=0): state IDLE, all outputs 0, `time_left`=0, pointer=PC_SEED.
- Outputs are Moore, registered from state.
- `player_move` in cycle n → `shot_req`=1 in cycle n+1.
- `shot_ack` sampled in cycle m → `shot_req`=0 and counters/flags updated in cycle m+1. `shot_ack` may arrive in the first request cycle.
- PC aim-to-request latency is one cycle. A dup retry costs 2 cycles per attempt.
- `time_left` is frozen outside P_WAIT.
- Counters saturate at HITS_TO_WIN.
- Reset asserted mid-transaction drops `shot_req` immediately. The board store must tolerate an abandoned request.

## Configuration
- `TURN_TIMER_EN` defined: turn timer active as described.
- Not defined: `tick` ignored, `time_left` tied to 0, and P_WAIT waits indefinitely for `player_move`.

## Test plan
- Reset during PC_SHOT with `shot_req`=1 → all outputs 0 in the same cycle. After release, state is IDLE and the next PC aim uses PC_SEED+PC_STRIDE.
- Game start, then `player_move` at (2,5) with ack miss → `shot_req`/`shot_target`=0 at (2,5). Next, PC shot at 6'h2D+37 = 6'h12 → (2,2), `shot_target`=1. Ack miss → P_WAIT, `time_left`=15.
- TURN_TICKS=3, three ticks with no move → `time_left` 3→2→1→0, then `pc_turn`=1. With `player_move` on the third tick → P_SHOT, `time_left`=1.
- Player ack with dup=1 → back to P_WAIT, `player_hits` and `time_left` unchanged. PC ack with dup=1 → new target = previous pointer + 37.
- HITS_TO_WIN=2, two player hits → `is_victory`=1 the cycle after the second ack, `player_hits`=2. `start` pulse → IDLE, counters 0.
- HITS_TO_WIN=1, PC ack hit → `is_defeat`=1. Built without TURN_TIMER_EN, 100 ticks in P_WAIT → still P_WAIT, `time_left`=0.
